// File: rtl/vga_pkg.sv
// Shared display geometry, pixel colour type and colour palette for the bar renderer.
package vga_pkg;

    localparam int H_ACT = 1280;
    localparam int V_ACT = 1024;
    localparam int XY_W  = 12;
    localparam int CH_W  = 10;

    typedef struct packed {
        logic [CH_W-1:0] red;
        logic [CH_W-1:0] green;
        logic [CH_W-1:0] blue;
    } rgb_t;

    typedef enum logic [2:0] {
        PIX_BLANK,
        PIX_GAP,
        PIX_HL,
        PIX_BAR,
        PIX_BG
    } pix_class_t;

    localparam rgb_t COL_BLACK = '{red: 10'h000, green: 10'h000, blue: 10'h000};
    localparam rgb_t COL_HL    = '{red: 10'h3FF, green: 10'h000, blue: 10'h000};
    localparam rgb_t COL_BAR   = '{red: 10'h000, green: 10'h3FF, blue: 10'h000};
    localparam rgb_t COL_BG    = '{red: 10'h000, green: 10'h000, blue: 10'h080};

    function automatic int unsigned clamp_height(input int unsigned val, input int unsigned lim);
        return (val > lim) ? lim : val;
    endfunction

    function automatic rgb_t colour_of(input pix_class_t cls);
        rgb_t c;
        case (cls)
            PIX_HL:  c = COL_HL;
            PIX_BAR: c = COL_BAR;
            PIX_BG:  c = COL_BG;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_bar_col_tracker.sv
// Follows the scan position within a line as a bar index and a column inside that bar's slot.
module vga_bar_col_tracker
    import vga_pkg::*;
#(
    parameter  int N_BARS = 16,
    parameter  int BAR_W  = 80,
    localparam int IDX_W  = $clog2(N_BARS),
    localparam int COL_W  = $clog2(BAR_W)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [XY_W-1:0]  i_x,
    output logic [IDX_W-1:0] o_idx,
    output logic [IDX_W-1:0] o_idx_nxt,
    output logic [COL_W-1:0] o_col
);

    logic [IDX_W-1:0] r_idx;
    logic [COL_W-1:0] r_col;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [COL_W-1:0] w_col_nxt;

    // X==0 restarts the line; otherwise counting relies on X stepping by one pixel per clock.
    always_comb begin
        w_idx_nxt = r_idx;
        w_col_nxt = r_col;
        if (i_x == '0) begin
            w_idx_nxt = '0;
            w_col_nxt = '0;
        end else if (r_col == COL_W'(BAR_W - 1)) begin
            w_col_nxt = '0;
            if (r_idx != IDX_W'(N_BARS - 1)) begin
                w_idx_nxt = r_idx + 1'b1;
            end
        end else begin
            w_col_nxt = r_col + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
            r_col <= '0;
        end else begin
            r_idx <= w_idx_nxt;
            r_col <= w_col_nxt;
        end
    end

    assign o_idx     = r_idx;
    assign o_col     = r_col;
    assign o_idx_nxt = w_idx_nxt;

endmodule

// File: rtl/vga_bar_renderer.sv
// Bar-graph pixel source for VGA_Ctrl: double-buffered bar heights swapped at vsync,
// two-stage pipeline from scan position to registered colour.
module vga_bar_renderer #(
    parameter  int N_BARS  = 16,
    parameter  int VAL_W   = 10,
    parameter  int BAR_W   = 80,
    parameter  int BAR_GAP = 4,
    parameter  int H_ACT   = vga_pkg::H_ACT,
    parameter  int V_ACT   = vga_pkg::V_ACT,
    localparam int IDX_W   = $clog2(N_BARS)
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic [11:0]      iVGA_X,
    input  logic [11:0]      iVGA_Y,
    input  logic             iVS,
    input  logic             iWr_valid,
    output logic             oWr_ready,
    input  logic [IDX_W-1:0] iWr_addr,
    input  logic [VAL_W-1:0] iWr_data,
    input  logic             iHl_en,
    input  logic [IDX_W-1:0] iHl_idx,
    output logic [9:0]       oRed,
    output logic [9:0]       oGreen,
    output logic [9:0]       oBlue,
    output logic [15:0]      oFrame_cnt
);

    import vga_pkg::*;

    localparam int COL_W = $clog2(BAR_W);

    logic [VAL_W-1:0] r_back  [N_BARS];
    logic [VAL_W-1:0] r_front [N_BARS];
    logic             r_vs_d;
    logic             r_rdy_en;
    logic [15:0]      r_frame_cnt;
    logic             r_hl_en;
    logic [IDX_W-1:0] r_hl_idx;

    logic [VAL_W-1:0] r_s1_val;
    logic [11:0]      r_s1_yinv;
    logic             r_s1_act;
    rgb_t             r_rgb;

    logic             w_swap;
    logic             w_wr_fire;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [COL_W-1:0] w_col;
    int unsigned      w_height;
    logic             w_lit;
    logic             w_gap;
    pix_class_t       w_class;

    assign w_swap    = r_vs_d & ~iVS;
    assign oWr_ready = r_rdy_en & ~w_swap;
    assign w_wr_fire = iWr_valid & oWr_ready;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_vs_d   <= 1'b0;
            r_rdy_en <= 1'b0;
        end else begin
            r_vs_d   <= iVS;
            r_rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < N_BARS; i++) begin
                r_back[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_back[iWr_addr] <= iWr_data;
        end
    end

    // The displayed bank and highlight only change at frame start so a frame never tears.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < N_BARS; i++) begin
                r_front[i] <= '0;
            end
            r_frame_cnt <= '0;
            r_hl_en     <= 1'b0;
            r_hl_idx    <= '0;
        end else if (w_swap) begin
            for (int i = 0; i < N_BARS; i++) begin
                r_front[i] <= r_back[i];
            end
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_hl_en     <= iHl_en;
            r_hl_idx    <= iHl_idx;
        end
    end

    vga_bar_col_tracker #(
        .N_BARS (N_BARS),
        .BAR_W  (BAR_W)
    ) u_col_tracker (
        .i_clk     (iCLK),
        .i_rst_n   (iRST_N),
        .i_x       (iVGA_X),
        .o_idx     (w_idx),
        .o_idx_nxt (w_idx_nxt),
        .o_col     (w_col)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_s1_val  <= '0;
            r_s1_yinv <= '0;
            r_s1_act  <= 1'b0;
        end else begin
            r_s1_val  <= r_front[w_idx_nxt];
            r_s1_yinv <= 12'(V_ACT - 1) - iVGA_Y;
            r_s1_act  <= (iVGA_X < 12'(H_ACT)) && (iVGA_Y < 12'(V_ACT));
        end
    end

    // Flipped Y grows upward from the bottom line, so a bar of height h lights yinv 0..h-1.
    always_comb begin
        w_height = clamp_height(32'(r_s1_val), 32'(V_ACT));
        w_lit    = 32'(r_s1_yinv) < w_height;
        w_gap    = w_col >= COL_W'(BAR_W - BAR_GAP);
        w_class  = PIX_BG;
        if (!r_s1_act) begin
            w_class = PIX_BLANK;
        end else if (w_gap) begin
            w_class = PIX_GAP;
        end else if (w_lit && r_hl_en && (w_idx == r_hl_idx)) begin
            w_class = PIX_HL;
        end else if (w_lit) begin
            w_class = PIX_BAR;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_rgb <= COL_BLACK;
        end else begin
            r_rgb <= colour_of(w_class);
        end
    end

    assign oRed       = r_rgb.red;
    assign oGreen     = r_rgb.green;
    assign oBlue      = r_rgb.blue;
    assign oFrame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_vga_bar_renderer.sv
// Directed bench for vga_bar_renderer: scans whole lines and checks chosen pixels against hand-worked colours.
module tb_vga_bar_renderer;

    localparam logic [29:0] cBlack = 30'h0;
    localparam logic [29:0] cGreen = {10'h000, 10'h3FF, 10'h000};
    localparam logic [29:0] cRed   = {10'h3FF, 10'h000, 10'h000};
    localparam logic [29:0] cBlue  = {10'h000, 10'h000, 10'h080};

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [11:0] iVGA_X;
    logic [11:0] iVGA_Y;
    logic        iVS;
    logic        iWr_valid;
    logic        oWr_ready;
    logic [3:0]  iWr_addr;
    logic [10:0] iWr_data;
    logic        iHl_en;
    logic [3:0]  iHl_idx;
    logic [9:0]  oRed;
    logic [9:0]  oGreen;
    logic [9:0]  oBlue;
    logic [15:0] oFrame_cnt;

    int assertCount = 0;
    int failCount   = 0;
    logic [29:0] raw [0:1289];

    always #5 iCLK = ~iCLK;

    // Eleven-bit values so the over-height clamp can be exercised.
    vga_bar_renderer #(
        .VAL_W (11)
    ) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iVGA_X     (iVGA_X),
        .iVGA_Y     (iVGA_Y),
        .iVS        (iVS),
        .iWr_valid  (iWr_valid),
        .oWr_ready  (oWr_ready),
        .iWr_addr   (iWr_addr),
        .iWr_data   (iWr_data),
        .iHl_en     (iHl_en),
        .iHl_idx    (iHl_idx),
        .oRed       (oRed),
        .oGreen     (oGreen),
        .oBlue      (oBlue),
        .oFrame_cnt (oFrame_cnt)
    );

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [10:0] data);
        iWr_valid = 1'b1;
        iWr_addr  = addr;
        iWr_data  = data;
        tick();
        iWr_valid = 1'b0;
    endtask

    task automatic pulseVs();
        iVS = 1'b0;
        tick();
        iVS = 1'b1;
        tick();
    endtask

    // raw[i] is sampled one edge after X=i is driven, so it holds the pixel for X=i-1.
    task automatic scanLine(input logic [11:0] y);
        iVGA_Y = y;
        for (int i = 0; i <= 1282; i++) begin
            iVGA_X = 12'(i);
            tick();
            raw[i] = {oRed, oGreen, oBlue};
        end
        iVGA_X = '0;
    endtask

    function automatic logic [31:0] pix(input int x);
        return {2'b00, raw[x+1]};
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        iRST_N    = 1'b0;
        iVGA_X    = '0;
        iVGA_Y    = '0;
        iVS       = 1'b1;
        iWr_valid = 1'b0;
        iWr_addr  = '0;
        iWr_data  = '0;
        iHl_en    = 1'b0;
        iHl_idx   = '0;

        #2;
        checkOutput("rst_rgb", {oRed, oGreen, oBlue}, cBlack);
        checkOutput("rst_frame", oFrame_cnt, 0);
        checkOutput("rst_ready", oWr_ready, 0);
        repeat (3) tick();
        iRST_N = 1'b1;
        #1;
        checkOutput("ready_before_edge", oWr_ready, 0);
        tick();
        checkOutput("ready_after_edge", oWr_ready, 1);

        applyStimulus(4'd3, 11'd512);
        scanLine(12'd600);
        checkOutput("pre_swap_bar3", pix(240), cBlue);
        checkOutput("bg_bar0", pix(10), cBlue);
        checkOutput("gap_bar0", pix(78), cBlack);

        pulseVs();
        checkOutput("frame_1", oFrame_cnt, 1);
        scanLine(12'd600);
        checkOutput("bar3_left", pix(240), cGreen);
        checkOutput("bar3_right", pix(315), cGreen);
        checkOutput("bar3_gap_lo", pix(316), cBlack);
        checkOutput("bar3_gap_hi", pix(319), cBlack);
        checkOutput("bar2_gap", pix(239), cBlack);
        checkOutput("bar4_bg", pix(320), cBlue);
        scanLine(12'd511);
        checkOutput("bar3_y511", pix(240), cBlue);
        scanLine(12'd512);
        checkOutput("bar3_y512", pix(240), cGreen);

        applyStimulus(4'd0, 11'd100);
        scanLine(12'd1000);
        checkOutput("bar0_no_swap", pix(10), cBlue);
        pulseVs();
        checkOutput("frame_2", oFrame_cnt, 2);
        scanLine(12'd1000);
        checkOutput("bar0_y1000", pix(10), cGreen);
        scanLine(12'd923);
        checkOutput("bar0_y923", pix(10), cBlue);
        scanLine(12'd924);
        checkOutput("bar0_y924", pix(10), cGreen);

        iWr_valid = 1'b1;
        iWr_addr  = 4'd7;
        iWr_data  = 11'd300;
        iVS       = 1'b0;
        #1;
        checkOutput("ready_swap_cycle", oWr_ready, 0);
        tick();
        iVS = 1'b1;
        #1;
        checkOutput("ready_after_swap", oWr_ready, 1);
        tick();
        iWr_valid = 1'b0;
        checkOutput("frame_3", oFrame_cnt, 3);
        scanLine(12'd1000);
        checkOutput("held_write_hidden", pix(560), cBlue);
        pulseVs();
        scanLine(12'd1000);
        checkOutput("held_write_shown", pix(560), cGreen);
        checkOutput("frame_4", oFrame_cnt, 4);

        applyStimulus(4'd5, 11'd1023);
        applyStimulus(4'd6, 11'd2000);
        iHl_en  = 1'b1;
        iHl_idx = 4'd5;
        pulseVs();
        iHl_idx = 4'd6;
        scanLine(12'd0);
        checkOutput("bar5_y0", pix(400), cBlue);
        checkOutput("bar6_clamp_y0", pix(480), cGreen);
        scanLine(12'd1);
        checkOutput("hl_left", pix(400), cRed);
        checkOutput("hl_right", pix(475), cRed);
        checkOutput("hl_gap", pix(476), cBlack);
        checkOutput("hl_latched", pix(480), cGreen);
        checkOutput("x_beyond", pix(1280), cBlack);
        checkOutput("lat_1cyc", {2'b00, raw[80]}, cBlack);
        checkOutput("lat_2cyc", {2'b00, raw[81]}, cBlue);
        scanLine(12'd1024);
        checkOutput("y_beyond", pix(400), cBlack);

        iVGA_Y = 12'd600;
        for (int i = 0; i <= 250; i++) begin
            iVGA_X = 12'(i);
            tick();
        end
        checkOutput("pre_reset_green", {oRed, oGreen, oBlue}, cGreen);
        #3;
        iRST_N = 1'b0;
        #1;
        checkOutput("midline_rst_rgb", {oRed, oGreen, oBlue}, cBlack);
        checkOutput("midline_rst_frame", oFrame_cnt, 0);
        checkOutput("midline_rst_ready", oWr_ready, 0);
        iVGA_X = '0;
        tick();
        iRST_N = 1'b1;
        tick();
        checkOutput("midline_ready_back", oWr_ready, 1);
        scanLine(12'd600);
        checkOutput("banks_cleared", pix(240), cBlue);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
